// File: rtl/sixteen_bit_prio_decoder.sv
// Priority decoder: expands an encoded index into a one-hot vector held for
// HOLD cycles, with a sticky OR-accumulation of every decoded line.
module sixteen_bit_prio_decoder #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4,
    parameter int HOLD  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             idx_valid,
    output logic             idx_ready,
    input  logic [IDX_W-1:0] idx,
    input  logic             idx_none,
    output logic [WIDTH-1:0] Y,
    output logic             y_valid,
    output logic             done,
    output logic [WIDTH-1:0] sticky,
    input  logic             sticky_clr,
    output logic             err
);

    typedef enum logic {
        IDLE,
        HOLD_ST
    } state_t;

    localparam logic [IDX_W:0] W_LIM    = (IDX_W + 1)'(WIDTH);
    localparam logic [7:0]     CNT_INIT = 8'(HOLD - 1);

    state_t           state;
    state_t           state_nx;
    logic [7:0]       cnt;
    logic             xfer;
    logic             oor;
    logic             last;
    logic [WIDTH-1:0] dec;

    assign idx_ready = (state == IDLE);
    assign xfer      = idx_valid && idx_ready;
    assign oor       = ({1'b0, idx} >= W_LIM);
    assign last      = (state == HOLD_ST) && (cnt == 8'd0);

    // Out-of-range and "none" indices fall through to an all-zero vector
    always_comb begin
        dec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dec[i] = !idx_none && (idx == IDX_W'(i));
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (xfer) state_nx = HOLD_ST;
            HOLD_ST: if (cnt == 8'd0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y       <= '0;
            y_valid <= 1'b0;
            done    <= 1'b0;
            cnt     <= 8'd0;
            err     <= 1'b0;
        end else begin
            done <= last;
            if (xfer) begin
                Y       <= dec;
                y_valid <= 1'b1;
                cnt     <= CNT_INIT;
                err     <= err | (!idx_none && oor);
            end else if (state == HOLD_ST) begin
                if (cnt != 8'd0) begin
                    cnt <= cnt - 8'd1;
                end else begin
                    Y       <= '0;
                    y_valid <= 1'b0;
                end
            end
        end
    end

    // Clear takes effect before the new line is OR-ed in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= '0;
        end else if (xfer) begin
            sticky <= (sticky_clr ? '0 : sticky) | dec;
        end else if (sticky_clr) begin
            sticky <= '0;
        end
    end

endmodule

// File: tb/tb_sixteen_bit_prio_decoder.sv
// Directed bench for sixteen_bit_prio_decoder: default build plus a
// WIDTH=12 / HOLD=1 build for out-of-range and single-cycle windows.
module tb_sixteen_bit_prio_decoder;

    localparam int HOLD_A = 4;

    typedef struct {
        logic [3:0]  idx;
        logic        none;
        logic        clr;
        logic        hold_v;
        logic [15:0] y;
        logic [15:0] st;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        a_valid = 1'b0, a_ready, a_none = 1'b0, a_clr = 1'b0;
    logic [3:0]  a_idx = '0;
    logic [15:0] a_y, a_sticky;
    logic        a_yv, a_done, a_err;

    logic        b_valid = 1'b0, b_ready, b_none = 1'b0, b_clr = 1'b0;
    logic [3:0]  b_idx = '0;
    logic [11:0] b_y, b_sticky;
    logic        b_yv, b_done, b_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sixteen_bit_prio_decoder #(.WIDTH(16), .IDX_W(4), .HOLD(HOLD_A)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .idx_valid(a_valid), .idx_ready(a_ready),
        .idx(a_idx), .idx_none(a_none),
        .Y(a_y), .y_valid(a_yv), .done(a_done),
        .sticky(a_sticky), .sticky_clr(a_clr), .err(a_err)
    );

    sixteen_bit_prio_decoder #(.WIDTH(12), .IDX_W(4), .HOLD(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .idx_valid(b_valid), .idx_ready(b_ready),
        .idx(b_idx), .idx_none(b_none),
        .Y(b_y), .y_valid(b_yv), .done(b_done),
        .sticky(b_sticky), .sticky_clr(b_clr), .err(b_err)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns just after the done negedge
    task automatic txn(input vec_t v);
        int n;
        a_idx   = v.idx;
        a_none  = v.none;
        a_clr   = v.clr;
        a_valid = 1'b1;
        n = 0;
        while (!a_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!a_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            a_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (!v.hold_v) a_valid = 1'b0;
        a_clr = 1'b0;
        chk("y_first", 32'(a_y), 32'(v.y));
        chk("yv_first", 32'(a_yv), 32'd1);
        chk("ready_busy", 32'(a_ready), 32'd0);
        chk("sticky", 32'(a_sticky), 32'(v.st));
        chk("err", 32'(a_err), 32'(v.err));
        chk("done_early", 32'(a_done), 32'd0);
        for (int c = 1; c < HOLD_A; c++) begin
            @(negedge clk);
            chk("y_hold", 32'(a_y), 32'(v.y));
            chk("yv_hold", 32'(a_yv), 32'd1);
            chk("done_hold", 32'(a_done), 32'd0);
        end
        @(negedge clk);
        chk("done_pulse", 32'(a_done), 32'd1);
        chk("y_end", 32'(a_y), 32'd0);
        chk("yv_end", 32'(a_yv), 32'd0);
        chk("ready_end", 32'(a_ready), 32'd1);
    endtask

    vec_t tv[$];

    initial begin
        logic [15:0] one;
        vec_t v;
        one = 16'h0001;

        tv.push_back('{4'd5, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0020, 1'b0});
        for (int i = 0; i < 16; i++) begin
            v = '{4'(i), 1'b0, 1'b0, 1'b1, one << i,
                  16'h0020 | 16'((32'd1 << (i + 1)) - 1), 1'b0};
            tv.push_back(v);
        end
        tv.push_back('{4'd9, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b0});
        tv.push_back('{4'd0, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0001, 1'b0});
        tv.push_back('{4'd5, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0021, 1'b0});
        tv.push_back('{4'd15, 1'b0, 1'b1, 1'b0, 16'h8000, 16'h8000, 1'b0});

        repeat (2) @(negedge clk);
        chk("rst_y", 32'(a_y), 32'd0);
        chk("rst_yv", 32'(a_yv), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_sticky", 32'(a_sticky), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(a_ready), 32'd1);

        foreach (tv[i]) txn(tv[i]);
        a_valid = 1'b0;

        @(negedge clk);
        chk("done_clear", 32'(a_done), 32'd0);
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        chk("clr_alone", 32'(a_sticky), 32'd0);

        // Abort a window with reset two cycles in
        a_idx = 4'd3;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        chk("abort_y", 32'(a_y), 32'h0008);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_y_async", 32'(a_y), 32'd0);
        chk("abort_yv_async", 32'(a_yv), 32'd0);
        chk("abort_sticky", 32'(a_sticky), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 32'(a_done), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(a_ready), 32'd1);
        chk("abort_no_done2", 32'(a_done), 32'd0);
        txn('{4'd3, 1'b0, 1'b0, 1'b0, 16'h0008, 16'h0008, 1'b0});

        // Narrow build: out-of-range index, one-cycle window
        chk("b_err_init", 32'(b_err), 32'd0);
        b_idx = 4'd13;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        chk("b_oor_y", 32'(b_y), 32'd0);
        chk("b_oor_yv", 32'(b_yv), 32'd1);
        chk("b_oor_err", 32'(b_err), 32'd1);
        chk("b_oor_ready", 32'(b_ready), 32'd0);
        @(negedge clk);
        chk("b_oor_done", 32'(b_done), 32'd1);
        chk("b_oor_yv_end", 32'(b_yv), 32'd0);
        chk("b_oor_sticky", 32'(b_sticky), 32'd0);
        b_clr = 1'b1;
        @(negedge clk);
        b_clr = 1'b0;
        chk("b_err_keep", 32'(b_err), 32'd1);
        chk("b_done_clr", 32'(b_done), 32'd0);
        b_idx = 4'd11;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        chk("b_top_y", 32'(b_y), 32'h800);
        chk("b_top_sticky", 32'(b_sticky), 32'h800);
        @(negedge clk);
        chk("b_top_done", 32'(b_done), 32'd1);
        chk("b_top_y_end", 32'(b_y), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sixteen_bit_prio_decoder.md
Name: sixteen_bit_prio_decoder

Overview:
- Return-path companion to the 16-bit priority encoder: expands a 4-bit encoded index (plus "none" flag) back into a 16-bit one-hot vector.
- Accepts one index per transaction over a valid/ready handshake.
- Drives the one-hot vector for a programmable number of cycles, then signals completion.
- Keeps a sticky OR-accumulation of every decoded line, for use by downstream control and bench scoreboards.

Parameters:
- WIDTH, 16, number of one-hot output lines.
- IDX_W, 4, index width; must satisfy 2**IDX_W >= WIDTH.
- HOLD, 4, cycles Y stays asserted per transaction; legal range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- idx_valid  in  1  index transfer request.
- idx_ready  out  1  block can accept an index.
- idx  in  IDX_W  encoded index; 0 = LSB line.
- idx_none  in  1  encoder reported all-zero input; decode to zero vector.
- Y  out  WIDTH  registered one-hot (or zero) output.
- y_valid  out  1  Y holds a live decode.
- done  out  1  single-cycle pulse when a hold window ends.
- sticky  out  WIDTH  OR of all vectors decoded since reset or last clear.
- sticky_clr  in  1  synchronous clear of sticky.
- err  out  1  sticky flag: an index >= WIDTH was received with idx_none=0.

Behaviour:
- Reset (rst_n low, async): state IDLE; Y=0, y_valid=0, done=0, sticky=0, err=0, hold counter=0. No transfer is registered while rst_n is low.
- Reset mid-transaction aborts immediately: Y drops to 0 asynchronously; no done pulse is generated.
- State IDLE: idx_ready=1 (combinational from state). Transfer occurs on a clock edge where idx_valid && idx_ready.
- On transfer at edge k:
  - Y <= idx_none ? 0 : (idx < WIDTH ? 1<<idx : 0); y_valid <= 1; cnt <= HOLD-1; state <= HOLD_ST.
  - err <= err | (!idx_none && idx >= WIDTH).
- State HOLD_ST: idx_ready=0; idx/idx_valid ignored.
  - If cnt != 0: cnt <= cnt-1.
  - If cnt == 0: Y <= 0; y_valid <= 0; done <= 1; state <= IDLE.
- Timing: Y and y_valid are high for exactly HOLD cycles (edges k+1 .. k+HOLD). done is high for the single cycle after edge k+HOLD, coincident with idx_ready returning to 1.
- done is cleared on the following edge unless another window ends there. Back-to-back spacing is at least HOLD+1 cycles between transfers.
- HOLD=1: Y is high for exactly one cycle; done follows immediately.
- idx_none=1 transaction: full handshake and hold window still run; Y=0 but y_valid=1 for HOLD cycles; sticky is unchanged.
- sticky: on transfer, sticky <= sticky | decoded.
  - sticky_clr without transfer: sticky <= 0.
  - sticky_clr on the same edge as a transfer: sticky <= decoded (clear first, then set).
  - sticky_clr does not affect err; err is cleared only by reset.
- Out-of-range index (possible only when WIDTH < 2**IDX_W): decodes to a zero vector, sets err, completes the window normally.
- Y is always one-hot or zero; never more than one bit set.

Test Plan:
- Reset release, idx=5, idx_valid=1 one cycle, HOLD=4 -> Y=16'h0020 with y_valid=1 for 4 cycles; done pulses 1 cycle; idx_ready low for 4 cycles then 1; sticky=16'h0020.
- Sweep idx 0..15 back-to-back with idx_valid held high -> Y walks 16'h0001..16'h8000, one transfer every 5 cycles; final sticky=16'hFFFF; err=0.
- idx_none=1, idx=9 -> Y=0, y_valid=1 for 4 cycles, done pulses, sticky unchanged.
- sticky=16'h0021, sticky_clr asserted on the same edge as a transfer of idx=15 -> sticky=16'h8000. Next cycle sticky_clr alone -> sticky=0.
- rst_n dropped 2 cycles into a window for idx=3 -> Y=0 and y_valid=0 immediately; no done pulse; after release idx_ready=1 and a new transfer of idx=3 completes normally.
- Parameters WIDTH=12, HOLD=1, idx=13 -> Y=0 for 1 cycle, y_valid=1, err=1 and stays 1 after sticky_clr.
